// File: rtl/count_run_packer.sv
// Collapses a repeating-count stream (0,1,2,2,3,3,3,...) into (value, run, last) pairs,
// checks each run against the expected pattern and queues pairs in a small FIFO.
module count_run_packer #(
    parameter  int N     = 32,
    parameter  int DEPTH = 4,
    localparam int W     = $clog2(N),
    localparam int RW    = $clog2(N + 1)
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          i_valid,
    input  logic [W-1:0]  i_count,
    input  logic          i_end,
    output logic          o_valid,
    input  logic          o_ready,
    output logic [W-1:0]  o_value,
    output logic [RW-1:0] o_run,
    output logic          o_last,
    output logic          o_err,
    output logic          o_ovf
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    typedef enum logic {S_IDLE, S_RUN} state_e;

    typedef struct packed {
        logic [W-1:0]  value;
        logic [RW-1:0] run;
        logic          last;
    } pair_t;

    state_e        state_q, state_d;
    logic [W-1:0]  cur_value_q, cur_value_d;
    logic [RW-1:0] run_cnt_q, run_cnt_d;
    logic          err_q, err_d;
    logic          ovf_q, ovf_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    pair_t         mem_q [DEPTH];
    pair_t         mem_d [DEPTH];

    pair_t         push_a, push_b;
    logic [1:0]    n_push;
    logic          err_now;
    logic [RW-1:0] run_inc;
    logic [PW-1:0] occupancy, free_slots, wr_ptr_b;
    logic          drop, pop;
    pair_t         head;

    // A run closed by the end marker may be cut short, but never over-long.
    function automatic logic run_bad(input pair_t p);
        logic [RW-1:0] expected;
        expected = (p.value == '0) ? RW'(1) : RW'(p.value);
        return p.last ? (p.run > expected) : (p.run != expected);
    endfunction

    always_comb begin
        state_d     = state_q;
        cur_value_d = cur_value_q;
        run_cnt_d   = run_cnt_q;
        push_a      = '0;
        push_b      = '0;
        n_push      = 2'd0;
        err_now     = 1'b0;
        run_inc     = (run_cnt_q == '1) ? run_cnt_q : run_cnt_q + 1'b1;
        if (i_valid) begin
            case (state_q)
                S_IDLE: begin
                    cur_value_d = i_count;
                    run_cnt_d   = RW'(1);
                    if (i_count != '0) err_now = 1'b1;
                    if (i_end) begin
                        push_a      = '{value: i_count, run: RW'(1), last: 1'b1};
                        n_push      = 2'd1;
                        cur_value_d = '0;
                        run_cnt_d   = '0;
                    end else begin
                        state_d = S_RUN;
                    end
                end
                default: begin
                    if (i_count == cur_value_q) begin
                        run_cnt_d = run_inc;
                        if (i_end) begin
                            push_a      = '{value: cur_value_q, run: run_inc, last: 1'b1};
                            n_push      = 2'd1;
                            state_d     = S_IDLE;
                            cur_value_d = '0;
                            run_cnt_d   = '0;
                        end
                    end else begin
                        push_a = '{value: cur_value_q, run: run_cnt_q, last: 1'b0};
                        n_push = 2'd1;
                        if (i_count != cur_value_q + 1'b1) err_now = 1'b1;
                        cur_value_d = i_count;
                        run_cnt_d   = RW'(1);
                        if (i_end) begin
                            push_b      = '{value: i_count, run: RW'(1), last: 1'b1};
                            n_push      = 2'd2;
                            state_d     = S_IDLE;
                            cur_value_d = '0;
                            run_cnt_d   = '0;
                        end
                    end
                end
            endcase
        end
        if (n_push != 2'd0 && run_bad(push_a)) err_now = 1'b1;
        if (n_push == 2'd2 && run_bad(push_b)) err_now = 1'b1;
        err_d = err_q | err_now;
    end

    // Free space is judged before any same-cycle pop; a cycle's pushes are all-or-nothing.
    always_comb begin
        occupancy  = wr_ptr_q - rd_ptr_q;
        free_slots = PW'(DEPTH) - occupancy;
        drop       = (n_push != 2'd0) && (free_slots < PW'(n_push));
        pop        = o_valid && o_ready;
        wr_ptr_b   = wr_ptr_q + 1'b1;
        mem_d      = mem_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q + PW'(pop);
        ovf_d      = ovf_q | drop;
        if (!drop && n_push != 2'd0) begin
            mem_d[wr_ptr_q[AW-1:0]] = push_a;
            if (n_push == 2'd2) mem_d[wr_ptr_b[AW-1:0]] = push_b;
            wr_ptr_d = wr_ptr_q + PW'(n_push);
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= S_IDLE;
            cur_value_q <= '0;
            run_cnt_q   <= '0;
            err_q       <= 1'b0;
            ovf_q       <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            state_q     <= state_d;
            cur_value_q <= cur_value_d;
            run_cnt_q   <= run_cnt_d;
            err_q       <= err_d;
            ovf_q       <= ovf_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            mem_q       <= mem_d;
        end
    end

    // Valid/ready: the head pair is held stable while o_valid && !o_ready; it leaves on o_valid && o_ready.
    assign o_valid = (wr_ptr_q != rd_ptr_q);
    assign head    = mem_q[rd_ptr_q[AW-1:0]];
    assign o_value = o_valid ? head.value : '0;
    assign o_run   = o_valid ? head.run   : '0;
    assign o_last  = o_valid ? head.last  : 1'b0;
    assign o_err   = err_q;
    assign o_ovf   = ovf_q;

endmodule
